// File: rtl/thermistor_adc_sampler_pkg.sv
// Shared constants and state encodings for the thermistor ADC sampler and
// the regulator-side logic that consumes its live temperature code.
package thermistor_adc_sampler_pkg;

    localparam int unsigned FRAME_SCLKS     = 16;
    localparam int unsigned DATA_FIRST_EDGE = 4;
    localparam int unsigned DATA_BITS       = 12;
    localparam logic [7:0]  TEMP_FAULT_CODE = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StCsSetup,
        StShift,
        StCsHold,
        StAccum
    } adc_state_e;

    // SCLK rising edges are numbered from 1; edges 4..15 carry D11..D0.
    function automatic logic is_data_edge(input int unsigned edge_num);
        return (edge_num >= DATA_FIRST_EDGE) && (edge_num < DATA_FIRST_EDGE + DATA_BITS);
    endfunction

endpackage

// File: rtl/thermistor_adc_sampler_spi_adc_rx.sv
// Read-only SPI receiver for an MCP3201-class ADC: drives CS_n/SCLK for one
// 16-clock frame per start pulse and returns the 12-bit conversion with done_o.
module thermistor_adc_sampler_spi_adc_rx
    import thermistor_adc_sampler_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 miso_i,
    output logic                 cs_n_o,
    output logic                 sclk_o,
    output logic                 idle_o,
    output logic                 done_o,
    output logic [DATA_BITS-1:0] data_o
);

    localparam int unsigned DivW  = $clog2(CLK_DIV);
    localparam int unsigned SclkW = $clog2(FRAME_SCLKS);

    adc_state_e           state_q;
    logic [DivW-1:0]      div_q;
    logic [SclkW-1:0]     sclk_cnt_q;
    logic                 cs_n_q;
    logic                 sclk_q;
    logic                 done_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 div_last;

    assign div_last = (div_q == DivW'(CLK_DIV - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            div_q      <= '0;
            sclk_cnt_q <= '0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            done_q     <= 1'b0;
            shreg_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StCsSetup;
                        cs_n_q  <= 1'b0;
                        div_q   <= '0;
                    end
                end
                StCsSetup: begin
                    if (div_last) begin
                        div_q      <= '0;
                        sclk_cnt_q <= '0;
                        state_q    <= StShift;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                StShift: begin
                    if (div_last) begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            // Last clock of the high phase: sample, then drop SCLK.
                            sclk_q <= 1'b0;
                            if (is_data_edge(32'(sclk_cnt_q) + 32'd1)) begin
                                shreg_q <= {shreg_q[DATA_BITS-2:0], miso_i};
                            end
                            if (sclk_cnt_q == SclkW'(FRAME_SCLKS - 1)) begin
                                cs_n_q  <= 1'b1;
                                state_q <= StCsHold;
                            end else begin
                                sclk_cnt_q <= sclk_cnt_q + 1'b1;
                            end
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                StCsHold: begin
                    if (div_last) begin
                        div_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cs_n_o = cs_n_q;
    assign sclk_o = sclk_q;
    assign idle_o = (state_q == StIdle);
    assign done_o = done_q;
    assign data_o = shreg_q;

endmodule

// File: rtl/thermistor_adc_sampler.sv
// Periodic thermistor sampler: starts an ADC frame every SAMPLE_PERIOD clocks,
// averages 2**AVG_LOG2 conversions and publishes a fault-guarded 8-bit code.
module thermistor_adc_sampler
    import thermistor_adc_sampler_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 25,
    parameter int unsigned SAMPLE_PERIOD = 50000,
    parameter int unsigned AVG_LOG2      = 3,
    parameter logic [11:0] FAULT_LO      = 12'd16,
    parameter logic [11:0] FAULT_HI      = 12'd4080
) (
    input  logic        i_Clock50MHz,
    input  logic        i_Reset_n,
    input  logic        i_Enable,
    output logic        o_Adc_Cs_n,
    output logic        o_Adc_Sclk,
    input  logic        i_Adc_Miso,
    output logic [7:0]  o_Live,
    output logic        o_Live_Valid,
    output logic [11:0] o_Raw,
    output logic        o_Sensor_Fault
);

    localparam int unsigned TimerW = $clog2(SAMPLE_PERIOD);
    localparam int unsigned AccW   = DATA_BITS + AVG_LOG2;
    localparam int unsigned CntW   = AVG_LOG2 + 1;

    logic [TimerW-1:0]    timer_q;
    logic                 tick;
    logic                 rx_start;
    logic                 rx_idle;
    logic                 rx_done;
    logic [DATA_BITS-1:0] rx_data;
    logic [AccW-1:0]      acc_q, acc_d, sum;
    logic [CntW-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [DATA_BITS-1:0] avg;
    logic                 avg_fault;
    logic                 publish;
    logic [7:0]           live_q;
    logic                 valid_q;
    logic [11:0]          raw_q;
    logic                 fault_q;

    assign tick = (timer_q == TimerW'(SAMPLE_PERIOD - 1));
    // rx_done marks the accumulate cycle; a tick landing there is dropped.
    assign rx_start = tick && i_Enable && rx_idle && !rx_done;

    thermistor_adc_sampler_spi_adc_rx #(
        .CLK_DIV(CLK_DIV)
    ) u_rx (
        .clk_i  (i_Clock50MHz),
        .rst_ni (i_Reset_n),
        .start_i(rx_start),
        .miso_i (i_Adc_Miso),
        .cs_n_o (o_Adc_Cs_n),
        .sclk_o (o_Adc_Sclk),
        .idle_o (rx_idle),
        .done_o (rx_done),
        .data_o (rx_data)
    );

    always_comb begin
        sum       = acc_q + AccW'(rx_data);
        cnt_inc   = cnt_q + 1'b1;
        avg       = DATA_BITS'(sum >> AVG_LOG2);
        avg_fault = (avg < FAULT_LO) || (avg > FAULT_HI);
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        publish   = 1'b0;
        if (rx_done) begin
            if (cnt_inc == CntW'(1 << AVG_LOG2)) begin
                acc_d   = '0;
                cnt_d   = '0;
                publish = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge i_Clock50MHz or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            timer_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            raw_q   <= '0;
            fault_q <= 1'b0;
            live_q  <= TEMP_FAULT_CODE;
        end else begin
            timer_q <= tick ? '0 : timer_q + 1'b1;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            valid_q <= publish;
            if (publish) begin
                raw_q   <= avg;
                fault_q <= avg_fault;
                live_q  <= avg_fault ? TEMP_FAULT_CODE : avg[DATA_BITS-1 -: 8];
            end
        end
    end

    assign o_Live         = live_q;
    assign o_Live_Valid   = valid_q;
    assign o_Raw          = raw_q;
    assign o_Sensor_Fault = fault_q;

endmodule

// File: tb/tb_thermistor_adc_sampler.sv
// Self-checking bench: an MCP3201-style ADC model feeds queued words, and
// expected averages/fault codes are computed from the words handed out.
module tb_thermistor_adc_sampler;

    localparam int unsigned ClkDiv = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        miso  = 1'b0;
    logic        cs_n;
    logic        sclk;
    logic [7:0]  live;
    logic        valid;
    logic [11:0] raw;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    // ADC model / monitor state
    logic [11:0] adc_q[$];
    logic [11:0] cur_word   = '0;
    logic        prev_cs    = 1'b1;
    logic        prev_sclk  = 1'b0;
    int          falls      = 0;
    int          rises      = 0;
    int          low_cnt    = 0;
    int          last_low   = 0;
    int          last_edges = 0;
    int          valid_cnt  = 0;

    thermistor_adc_sampler #(
        .CLK_DIV      (2),
        .SAMPLE_PERIOD(200),
        .AVG_LOG2     (2)
    ) dut (
        .i_Clock50MHz  (clk),
        .i_Reset_n     (rst_n),
        .i_Enable      (en),
        .o_Adc_Cs_n    (cs_n),
        .o_Adc_Sclk    (sclk),
        .i_Adc_Miso    (miso),
        .o_Live        (live),
        .o_Live_Valid  (valid),
        .o_Raw         (raw),
        .o_Sensor_Fault(fault)
    );

    always #5 clk = ~clk;

    // ADC behaviour: a new word per CS_n low window, bit for edge n presented after edge n rises.
    always @(negedge clk) begin
        if (prev_cs && !cs_n) begin
            falls++;
            low_cnt  = 0;
            rises    = 0;
            cur_word = (adc_q.size() > 0) ? adc_q.pop_front() : 12'h000;
        end
        if (!cs_n) low_cnt++;
        if (!prev_cs && cs_n) begin
            last_low   = low_cnt;
            last_edges = rises;
        end
        if (!prev_sclk && sclk) begin
            rises++;
            if (rises >= 4 && rises <= 15) miso = cur_word[15-rises];
            else miso = 1'($urandom);
        end
        if (valid) valid_cnt++;
        prev_cs   = cs_n;
        prev_sclk = sclk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [11:0] mean4(input logic [11:0] a, b, c, d);
        int s;
        s = int'(a) + int'(b) + int'(c) + int'(d);
        return 12'(s / 4);
    endfunction

    function automatic logic [7:0] live_of(input logic [11:0] avg);
        if (avg < 12'd16 || avg > 12'd4080) return 8'hFF;
        return 8'(avg / 16);
    endfunction

    task automatic run_avg(input logic [11:0] a, b, c, d, input string tag);
        int          fb;
        logic [11:0] avg;
        bit          ok;
        fb  = falls;
        avg = mean4(a, b, c, d);
        adc_q.push_back(a);
        adc_q.push_back(b);
        adc_q.push_back(c);
        adc_q.push_back(d);
        en = 1'b1;
        wait_valid(2000, ok);
        en = 1'b0;
        check({tag, " valid_seen"}, 32'(ok), 1);
        check({tag, " raw"}, 32'(raw), 32'(avg));
        check({tag, " live"}, 32'(live), 32'(live_of(avg)));
        check({tag, " fault"}, 32'(fault), 32'(avg < 12'd16 || avg > 12'd4080));
        check({tag, " frames"}, 32'(falls - fb), 4);
        step();
        check({tag, " valid_one_cycle"}, 32'(valid), 0);
    endtask

    initial begin
        logic [11:0] w[4];
        int          fb;
        int          vb;
        bit          ok;

        // Reset state
        repeat (5) step();
        check("rst cs_n", 32'(cs_n), 1);
        check("rst sclk", 32'(sclk), 0);
        check("rst live", 32'(live), 32'hFF);
        check("rst fault", 32'(fault), 0);
        check("rst valid", 32'(valid), 0);
        check("rst raw", 32'(raw), 0);
        rst_n = 1'b1;
        repeat (1000) step();
        check("disabled no frames", 32'(falls), 0);
        check("disabled cs_n", 32'(cs_n), 1);

        // Constant mid-scale and frame shape
        run_avg(12'h800, 12'h800, 12'h800, 12'h800, "t2");
        check("t2 raw const", 32'(raw), 32'h800);
        check("t2 live const", 32'(live), 32'h80);
        check("t2 sclk edges", 32'(last_edges), 16);
        check("t2 cs low clocks", 32'(last_low), 33 * ClkDiv);  // setup + 16 SCLK periods

        run_avg(12'h100, 12'h200, 12'h300, 12'h400, "t3");
        check("t3 raw const", 32'(raw), 32'h280);
        check("t3 live const", 32'(live), 32'h28);

        // Fault thresholds and boundaries
        run_avg(12'h000, 12'h000, 12'h000, 12'h000, "t4 zero");
        check("t4 zero fault", 32'(fault), 1);
        run_avg(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, "t4 full");
        check("t4 full fault", 32'(fault), 1);
        run_avg(12'd16, 12'd16, 12'd16, 12'd16, "t4 lo");
        check("t4 lo live", 32'(live), 32'h01);
        check("t4 lo fault", 32'(fault), 0);
        run_avg(12'd15, 12'd15, 12'd15, 12'd15, "t4 below");
        run_avg(12'd4080, 12'd4080, 12'd4080, 12'd4080, "t4 hi");
        check("t4 hi live", 32'(live), 32'hFF);
        check("t4 hi fault", 32'(fault), 0);
        run_avg(12'd4081, 12'd4081, 12'd4081, 12'd4081, "t4 above");

        // Random words
        for (int k = 0; k < 3; k++) begin
            run_avg(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                    12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), "rand");
        end

        // Enable dropped during the second frame's shift
        for (int k = 0; k < 4; k++) begin
            w[k] = 12'($urandom_range(16, 4080));
            adc_q.push_back(w[k]);
        end
        fb = falls;
        vb = valid_cnt;
        en = 1'b1;
        for (int i = 0; i < 1000 && falls - fb < 2; i++) step();
        check("t5 second frame", 32'(falls - fb), 2);
        repeat (10) step();
        check("t5 in frame", 32'(cs_n), 0);
        en = 1'b0;
        for (int i = 0; i < 200 && !cs_n; i++) step();
        check("t5 frame ends", 32'(cs_n), 1);
        check("t5 frame edges", 32'(last_edges), 16);
        repeat (600) step();
        check("t5 no new frames", 32'(falls - fb), 2);
        check("t5 no valid", 32'(valid_cnt - vb), 0);
        en = 1'b1;
        wait_valid(1000, ok);
        en = 1'b0;
        check("t5 valid_seen", 32'(ok), 1);
        check("t5 raw", 32'(raw), 32'(mean4(w[0], w[1], w[2], w[3])));
        check("t5 frames", 32'(falls - fb), 4);

        // Reset during the second frame's shift discards the partial average
        adc_q.push_back(12'hFF0);
        adc_q.push_back(12'hFF0);
        fb = falls;
        en = 1'b1;
        for (int i = 0; i < 1000 && falls - fb < 2; i++) step();
        for (int i = 0; i < 50 && !sclk; i++) step();
        check("t6 sclk high", 32'(sclk), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async cs_n", 32'(cs_n), 1);
        check("t6 async sclk", 32'(sclk), 0);
        en = 1'b0;
        adc_q.delete();
        repeat (3) step();
        check("t6 rst raw", 32'(raw), 0);
        check("t6 rst live", 32'(live), 32'hFF);
        rst_n = 1'b1;
        run_avg(12'h123, 12'h456, 12'h789, 12'h0AB, "t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
